ipsxe_floating_point_dotacc_v2_0: RTL and testbench



---
 rtl/ipsxe_floating_point_pkg.sv | 42 ++++
 rtl/ipsxe_floating_point_addtree_v1_0.sv | 40 ++++
 rtl/ipsxe_floating_point_dotacc_v2_0.sv | 231 +++++++++++++++++++++++
 tb/tb_ipsxe_floating_point_dotacc_v2_0.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/ipsxe_floating_point_pkg.sv
// Shared definitions for the floating-point IP family.
// Holds the width helpers used to size the multiply / adder-tree /
// accumulator datapath, the fixed-point saturation constants (64-bit wide,
// right-shift to the fixed width in use), the per-beat sideband struct
// and a constant clog2.
package ipsxe_floating_point_pkg;

  // Most-positive / most-negative fixed values, left-aligned in 64 bits.
  // Users take the top FX_W bits with a right shift of 64-FX_W.
  localparam logic [63:0] FLT_POS_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] FLT_NEG_MAX = 64'h8000_0000_0000_0000;

  // Control sideband travelling alongside a beat through the pipeline.
  typedef struct packed {
    logic valid;
    logic last;
    logic invalid;
  } beat_ctrl_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Full-precision signed product of two fixed words.
  function automatic int prod_width(input int fx_w);
    return 2 * fx_w;
  endfunction

  // Sum of n products without loss.
  function automatic int tree_width(input int fx_w, input int n);
    return prod_width(fx_w) + clog2(n);
  endfunction

  // Tree sum plus guard bits for up to 2^guard beats.
  function automatic int acc_width(input int fx_w, input int n, input int guard);
    return tree_width(fx_w, n) + guard;
  endfunction

endpackage

// File: rtl/ipsxe_floating_point_addtree_v1_0.sv
// Registered signed adder tree.
// Sums N signed W-bit inputs into one W+clog2(N)-bit result, one register
// stage. Ports: i_aclk clock, i_areset_n sync active-low reset,
// i_aclken clock enable, i_data packed inputs (input k at [k*W +: W]),
// o_sum registered signed sum.
module ipsxe_floating_point_addtree_v1_0
  import ipsxe_floating_point_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 64
) (
  input  logic                           i_aclk,
  input  logic                           i_areset_n,
  input  logic                           i_aclken,
  input  logic [N*W-1:0]                 i_data,
  output logic signed [W+clog2(N)-1:0]   o_sum
);

  localparam int SW = W + clog2(N);

  logic [N-1:0][SW-1:0] term;
  logic [SW-1:0]        sum_next;

  // Sign-extend every input to the full sum width so the plain modular
  // add below yields the correct signed total.
  for (genvar gi = 0; gi < N; gi++) begin : g_term
    assign term[gi] = SW'($signed(i_data[gi*W +: W]));
  end

  always_comb begin
    sum_next = '0;
    for (int k = 0; k < N; k++) sum_next = sum_next + term[k];
  end

  always_ff @(posedge i_aclk) begin
    if (!i_areset_n)   o_sum <= '0;
    else if (i_aclken) o_sum <= sum_next;
  end

endmodule

// File: rtl/ipsxe_floating_point_dotacc_v2_0.sv
// N-lane floating-point dot product with multi-beat accumulation.
// Pipeline: S1 float->fixed per lane, S2 signed products (optionally
// negated), S3 adder tree, S4 accumulator, S5 saturate + fixed->float.
// One result per packet, 5 enabled cycles after the tlast beat.
// Ports: i_aclk, i_areset_n (sync active-low), i_aclken (global hold),
// i_axi4s_a/b_tdata (lane i at [i*DATA_WIDTH +: DATA_WIDTH]),
// i_axi4s_tvalid / i_axi4s_tlast, i_sub_mask (1 = subtract lane),
// o_axi4s_result_tdata / _tvalid, o_overflow, o_invalid_op.
module ipsxe_floating_point_dotacc_v2_0
  import ipsxe_floating_point_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int FIXED_INT_BIT  = 24,
  parameter int FIXED_FRAC_BIT = 8,
  parameter int FLOAT_EXP_BIT  = 8,
  parameter int FLOAT_FRAC_BIT = 24,
  parameter int N_LANES        = 4,
  parameter int ACC_GUARD      = 8
) (
  input  logic                            i_aclk,
  input  logic                            i_areset_n,
  input  logic                            i_aclken,
  input  logic [N_LANES*DATA_WIDTH-1:0]   i_axi4s_a_tdata,
  input  logic [N_LANES*DATA_WIDTH-1:0]   i_axi4s_b_tdata,
  input  logic                            i_axi4s_tvalid,
  input  logic                            i_axi4s_tlast,
  input  logic [N_LANES-1:0]              i_sub_mask,
  output logic [DATA_WIDTH-1:0]           o_axi4s_result_tdata,
  output logic                            o_axi4s_result_tvalid,
  output logic                            o_overflow,
  output logic                            o_invalid_op
);

  localparam int FX_W     = FIXED_INT_BIT + FIXED_FRAC_BIT;
  localparam int PROD_W   = prod_width(FX_W);
  localparam int TREE_W   = tree_width(FX_W, N_LANES);
  localparam int ACC_W    = acc_width(FX_W, N_LANES, ACC_GUARD);
  // Products carry 2*FIXED_FRAC_BIT fraction bits; the output word keeps
  // FIXED_FRAC_BIT of them so it is back in the intermediate fixed format.
  localparam int SLICE_LO = FIXED_FRAC_BIT;
  localparam int SLICE_HI = FX_W + FIXED_FRAC_BIT - 1;
  localparam int CNT_W    = ACC_GUARD + 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(1) << ACC_GUARD;
  localparam logic [FX_W-1:0]  POS_MAX   = FX_W'(FLT_POS_MAX >> (64 - FX_W));
  localparam logic [FX_W-1:0]  NEG_MAX   = FX_W'(FLT_NEG_MAX >> (64 - FX_W));
  localparam int BIAS     = (1 << (FLOAT_EXP_BIT - 1)) - 1;
  localparam int EXP_MAX  = (1 << FLOAT_EXP_BIT) - 1;
  // Biased exponent at which the mantissa LSB weighs exactly one fixed LSB.
  localparam int FL2FX_K  = BIAS + FLOAT_FRAC_BIT - 1 - FIXED_FRAC_BIT;
  localparam int FL2FX_SAT = FL2FX_K + FX_W - FLOAT_FRAC_BIT;

  // Float -> fixed, magnitude truncated. Returns {invalid, value}.
  // NaN/Inf contribute 0 and raise invalid; subnormals flush to 0;
  // magnitudes that do not fit clamp to the fixed extremes.
  function automatic logic [FX_W:0] fl2fx(input logic [DATA_WIDTH-1:0] f);
    logic            sgn, inv;
    int              e;
    logic [FX_W-1:0] mant, mag, val;
    sgn  = f[DATA_WIDTH-1];
    e    = int'(f[DATA_WIDTH-2 -: FLOAT_EXP_BIT]);
    mant = '0;
    mant[FLOAT_FRAC_BIT-1:0] = {1'b1, f[FLOAT_FRAC_BIT-2:0]};
    inv  = (e == EXP_MAX);
    mag  = '0;
    if (inv || e == 0)      val = '0;
    else if (e >= FL2FX_SAT) val = sgn ? NEG_MAX : POS_MAX;
    else begin
      if (e >= FL2FX_K) mag = mant << (e - FL2FX_K);
      else              mag = mant >> (FL2FX_K - e);
      val = sgn ? -mag : mag;
    end
    return {inv, val};
  endfunction

  // Fixed -> float, round to nearest even.
  function automatic logic [DATA_WIDTH-1:0] fx2fl(input logic [FX_W-1:0] x);
    logic            sgn;
    logic [FX_W-1:0] mag, rem, half;
    logic [FX_W:0]   mant;
    int              p, sh, e;
    sgn = x[FX_W-1];
    mag = sgn ? -x : x;
    p   = -1;
    for (int k = 0; k < FX_W; k++) if (mag[k]) p = k;
    if (p < 0) return '0;
    e = p - FIXED_FRAC_BIT + BIAS;
    if (p <= FLOAT_FRAC_BIT - 1) begin
      mant = {1'b0, mag} << (FLOAT_FRAC_BIT - 1 - p);
    end else begin
      sh   = p - (FLOAT_FRAC_BIT - 1);
      mant = {1'b0, mag >> sh};
      rem  = mag & ((FX_W'(1) << sh) - FX_W'(1));
      half = FX_W'(1) << (sh - 1);
      if (rem > half || (rem == half && mant[0])) mant = mant + (FX_W+1)'(1);
      // Rounding carried into a new MSB: renormalise.
      if (mant[FLOAT_FRAC_BIT]) begin
        mant = mant >> 1;
        e++;
      end
    end
    return {sgn, FLOAT_EXP_BIT'(e), mant[FLOAT_FRAC_BIT-2:0]};
  endfunction

  // ---------------- S1 / S2: per-lane convert and multiply ----------------
  beat_ctrl_t           s1_reg, s2_reg, s3_reg;
  logic [N_LANES-1:0]   mask_s1_reg;
  logic [N_LANES-1:0]   lane_inv_next;
  logic [N_LANES*PROD_W-1:0] prod_flat;

  for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
    logic [FX_W:0]              a_cv, b_cv;
    logic [FX_W-1:0]            a_fx_reg, b_fx_reg;
    logic signed [PROD_W-1:0]   a_ext, b_ext, prod_next, prod_reg;

    assign a_cv = fl2fx(i_axi4s_a_tdata[gi*DATA_WIDTH +: DATA_WIDTH]);
    assign b_cv = fl2fx(i_axi4s_b_tdata[gi*DATA_WIDTH +: DATA_WIDTH]);
    assign lane_inv_next[gi] = a_cv[FX_W] | b_cv[FX_W];

    assign a_ext     = PROD_W'($signed(a_fx_reg));
    assign b_ext     = PROD_W'($signed(b_fx_reg));
    assign prod_next = a_ext * b_ext;

    always_ff @(posedge i_aclk) begin
      if (!i_areset_n) begin
        a_fx_reg <= '0;
        b_fx_reg <= '0;
        prod_reg <= '0;
      end else if (i_aclken) begin
        a_fx_reg <= a_cv[FX_W-1:0];
        b_fx_reg <= b_cv[FX_W-1:0];
        prod_reg <= mask_s1_reg[gi] ? -prod_next : prod_next;
      end
    end

    assign prod_flat[gi*PROD_W +: PROD_W] = prod_reg;
  end

  always_ff @(posedge i_aclk) begin
    if (!i_areset_n) begin
      s1_reg      <= '0;
      s2_reg      <= '0;
      s3_reg      <= '0;
      mask_s1_reg <= '0;
    end else if (i_aclken) begin
      // tlast / invalid only mean something on a valid beat.
      s1_reg.valid   <= i_axi4s_tvalid;
      s1_reg.last    <= i_axi4s_tvalid & i_axi4s_tlast;
      s1_reg.invalid <= i_axi4s_tvalid & (|lane_inv_next);
      mask_s1_reg    <= i_sub_mask;
      s2_reg         <= s1_reg;
      s3_reg         <= s2_reg;
    end
  end

  // ---------------- S3: adder tree ----------------
  logic signed [TREE_W-1:0] tree_sum;

  ipsxe_floating_point_addtree_v1_0 #(
    .N (N_LANES),
    .W (PROD_W)
  ) u_addtree (
    .i_aclk     (i_aclk),
    .i_areset_n (i_areset_n),
    .i_aclken   (i_aclken),
    .i_data     (prod_flat),
    .o_sum      (tree_sum)
  );

  // ---------------- S4: accumulator and sticky state ----------------
  logic signed [ACC_W-1:0] acc_reg, acc_next;
  logic [CNT_W-1:0]        beat_cnt_reg, cnt_next;
  logic                    first_beat_reg, inv_sticky_reg, cnt_ovf_reg, s4_valid_reg;

  always_comb begin
    acc_next = (first_beat_reg ? '0 : acc_reg) + ACC_W'(tree_sum);
    if (first_beat_reg)                cnt_next = CNT_W'(1);
    else if (beat_cnt_reg == CNT_LIMIT) cnt_next = beat_cnt_reg;
    else                               cnt_next = beat_cnt_reg + CNT_W'(1);
  end

  always_ff @(posedge i_aclk) begin
    if (!i_areset_n) begin
      acc_reg        <= '0;
      beat_cnt_reg   <= '0;
      first_beat_reg <= 1'b1;
      inv_sticky_reg <= 1'b0;
      cnt_ovf_reg    <= 1'b0;
      s4_valid_reg   <= 1'b0;
    end else if (i_aclken) begin
      s4_valid_reg <= s3_reg.valid & s3_reg.last;
      if (s3_reg.valid) begin
        acc_reg        <= acc_next;
        beat_cnt_reg   <= cnt_next;
        first_beat_reg <= s3_reg.last;
        inv_sticky_reg <= (inv_sticky_reg & ~first_beat_reg) | s3_reg.invalid;
        // A packet of exactly 2^ACC_GUARD beats is legal; one more is not.
        cnt_ovf_reg    <= (cnt_ovf_reg & ~first_beat_reg) |
                          (cnt_next == CNT_LIMIT && !s3_reg.last);
      end
    end
  end

  // ---------------- S5: saturate and convert ----------------
  logic [ACC_W-SLICE_HI-1:0] acc_top;
  logic                      slice_ovf;
  logic [FX_W-1:0]           slice_fx;

  always_comb begin
    acc_top   = acc_reg[ACC_W-1:SLICE_HI];
    slice_ovf = !((&acc_top) || !(|acc_top));
    if (slice_ovf) slice_fx = acc_reg[ACC_W-1] ? NEG_MAX : POS_MAX;
    else           slice_fx = acc_reg[SLICE_HI:SLICE_LO];
  end

  always_ff @(posedge i_aclk) begin
    if (!i_areset_n) begin
      o_axi4s_result_tdata  <= '0;
      o_axi4s_result_tvalid <= 1'b0;
      o_overflow            <= 1'b0;
      o_invalid_op          <= 1'b0;
    end else if (i_aclken) begin
      o_axi4s_result_tvalid <= s4_valid_reg;
      if (s4_valid_reg) begin
        o_axi4s_result_tdata <= fx2fl(slice_fx);
        o_overflow           <= slice_ovf | cnt_ovf_reg;
        o_invalid_op         <= inv_sticky_reg;
      end
    end
  end

endmodule

// File: tb/tb_ipsxe_floating_point_dotacc_v2_0.sv
module tb_ipsxe_floating_point_dotacc_v2_0;

  localparam logic [31:0] F0  = 32'h0000_0000;
  localparam logic [31:0] F05 = 32'h3F00_0000;
  localparam logic [31:0] F1  = 32'h3F80_0000;
  localparam logic [31:0] FM15 = 32'hBFC0_0000;
  localparam logic [31:0] F2  = 32'h4000_0000;
  localparam logic [31:0] F3  = 32'h4040_0000;
  localparam logic [31:0] F4  = 32'h4080_0000;
  localparam logic [31:0] FBIG = 32'h4A80_0000;
  localparam logic [31:0] FNAN = 32'h7FC0_0000;

  logic         clk = 1'b0;
  logic         areset_n, aclken;
  logic [127:0] a_tdata, b_tdata;
  logic         tvalid, tlast;
  logic [3:0]   sub_mask;
  logic [31:0]  r_tdata;
  logic         r_tvalid, ovf, inv;

  typedef struct {
    logic [31:0] data;
    logic        ovf;
    logic        inv;
    int          edge_n;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   failed = 0;
  int   en_edges = 0;
  logic last_en = 1'b0;

  always #5 clk = ~clk;

  ipsxe_floating_point_dotacc_v2_0 dut (
    .i_aclk                (clk),
    .i_areset_n            (areset_n),
    .i_aclken              (aclken),
    .i_axi4s_a_tdata       (a_tdata),
    .i_axi4s_b_tdata       (b_tdata),
    .i_axi4s_tvalid        (tvalid),
    .i_axi4s_tlast         (tlast),
    .i_sub_mask            (sub_mask),
    .o_axi4s_result_tdata  (r_tdata),
    .o_axi4s_result_tvalid (r_tvalid),
    .o_overflow            (ovf),
    .o_invalid_op          (inv)
  );

  always @(posedge clk) begin
    last_en = aclken;
    if (aclken) en_edges++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: one comparison set per enabled-cycle result strobe.
  always @(negedge clk) begin
    if (last_en && r_tvalid) begin
      exp_t e;
      if (sb.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_strobe: got data %h at edge %0d, expected no result", r_tdata, en_edges);
      end else begin
        e = sb.pop_front();
        $display("[TB] result %h ovf=%0b inv=%0b edge=%0d (expect %h %0b %0b edge=%0d)",
                 r_tdata, ovf, inv, en_edges, e.data, e.ovf, e.inv, e.edge_n);
        check("result_data", r_tdata, e.data);
        check("overflow", {31'd0, ovf}, {31'd0, e.ovf});
        check("invalid_op", {31'd0, inv}, {31'd0, e.inv});
        check("latency_edge", en_edges, e.edge_n);
      end
    end
  end

  task automatic send(input logic [127:0] a, input logic [127:0] b, input logic [3:0] m,
                      input logic last, input logic [31:0] ed, input logic eo, input logic ei);
    exp_t e;
    @(negedge clk);
    a_tdata  = a;
    b_tdata  = b;
    sub_mask = m;
    tvalid   = 1'b1;
    tlast    = last;
    if (last) begin
      // Sampled at the next edge, result registered four enabled edges later.
      e.data = ed; e.ovf = eo; e.inv = ei; e.edge_n = en_edges + 5;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input logic last_bit);
    @(negedge clk);
    tvalid = 1'b0;
    tlast  = last_bit;
  endtask

  initial begin
    areset_n = 1'b0; aclken = 1'b1;
    a_tdata = '0; b_tdata = '0; tvalid = 1'b0; tlast = 1'b0; sub_mask = '0;
    repeat (3) @(negedge clk);
    check("reset_tdata", r_tdata, 32'h0);
    check("reset_tvalid", {31'd0, r_tvalid}, 32'h0);
    check("reset_overflow", {31'd0, ovf}, 32'h0);
    check("reset_invalid", {31'd0, inv}, 32'h0);
    areset_n = 1'b1;

    // 1+2+3+4 = 10.0
    send({F4, F3, F2, F1}, {F1, F1, F1, F1}, 4'b0000, 1'b1, 32'h4120_0000, 1'b0, 1'b0);
    idle(1'b0);
    // Three back-to-back beats of 4 x 1.0 -> 12.0
    send({F1, F1, F1, F1}, {F1, F1, F1, F1}, 4'b0000, 1'b0, 32'h0, 1'b0, 1'b0);
    send({F1, F1, F1, F1}, {F1, F1, F1, F1}, 4'b0000, 1'b0, 32'h0, 1'b0, 1'b0);
    send({F1, F1, F1, F1}, {F1, F1, F1, F1}, 4'b0000, 1'b1, 32'h4140_0000, 1'b0, 1'b0);
    // Lane 1 subtracted: 1-2+3+4 = 6.0
    send({F4, F3, F2, F1}, {F1, F1, F1, F1}, 4'b0010, 1'b1, 32'h40C0_0000, 1'b0, 1'b0);
    // 2^22 * 4 overflows the fixed output -> clamp, 2^23
    send({F0, F0, F0, FBIG}, {F0, F0, F0, F4}, 4'b0000, 1'b1, 32'h4B00_0000, 1'b1, 1'b0);
    send({F0, F0, F0, F1}, {F0, F0, F0, F1}, 4'b0000, 1'b1, 32'h3F80_0000, 1'b0, 1'b0);
    // Negative result: -1.5 * 2.0 = -3.0
    send({F0, F0, F0, FM15}, {F0, F0, F0, F2}, 4'b0000, 1'b1, 32'hC040_0000, 1'b0, 1'b0);
    // Bubble plus a tlast on an invalid cycle inside a packet -> 8.0
    send({F1, F1, F1, F1}, {F1, F1, F1, F1}, 4'b0000, 1'b0, 32'h0, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b0);
    send({F1, F1, F1, F1}, {F1, F1, F1, F1}, 4'b0000, 1'b1, 32'h4100_0000, 1'b0, 1'b0);
    repeat (6) idle(1'b0);

    // Reset discards a partial packet.
    send({F1, F1, F1, F1}, {F1, F1, F1, F1}, 4'b0000, 1'b0, 32'h0, 1'b0, 1'b0);
    send({F1, F1, F1, F1}, {F1, F1, F1, F1}, 4'b0000, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk); tvalid = 1'b0; tlast = 1'b0; areset_n = 1'b0;
    @(negedge clk); areset_n = 1'b1;
    send({F0, F0, F0, F05}, {F0, F0, F0, F2}, 4'b0000, 1'b1, 32'h3F80_0000, 1'b0, 1'b0);

    // NaN lane (contributes 0) with a 3-cycle enable stall mid-pipeline: 1+2+4 = 7.0
    send({F4, FNAN, F2, F1}, {F1, F1, F1, F1}, 4'b0000, 1'b1, 32'h40E0_0000, 1'b0, 1'b1);
    idle(1'b0);
    @(negedge clk); aclken = 1'b0;
    repeat (3) @(negedge clk);
    aclken = 1'b1;
    send({F0, F0, F0, F1}, {F0, F0, F0, F1}, 4'b0000, 1'b1, 32'h3F80_0000, 1'b0, 1'b0);

    // Exactly 2^ACC_GUARD beats: legal, no overflow.
    for (int i = 0; i < 256; i++)
      send('0, '0, 4'b0000, (i == 255), 32'h0, 1'b0, 1'b0);
    // One beat more: beat counter forces overflow.
    for (int i = 0; i < 257; i++)
      send('0, '0, 4'b0000, (i == 256), 32'h0, 1'b1, 1'b0);
    idle(1'b0);

    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      failed++;
      $display("FAIL drain: got %0d results outstanding, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
